output_port_arbiter: RTL and testbench

- Allocates one router output port among NUM_IN input ports using packet-level round-robin.
- Once an input wins, the port stays locked to it until all FLITS_PER_PKT flits have crossed the crossbar.
- Tracks downstream buffer credits and allows a flit transfer only when a credit is available.
- One instance per output port. It drives the crossbar select and the per-input grant that the input-side flow control units consume.

---
 rtl/output_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_output_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//   Allocates one router output port among NUM_IN inputs. Arbitration is
//   round-robin at packet granularity. After an input wins, the port stays
//   locked to it until FLITS_PER_PKT flits have crossed. A credit counter
//   tracks free downstream buffer slots. A flit moves only when at least one
//   credit is available.
//
//   Optional build macro: OPA_CREDIT_CHECK_EN adds the sticky err_o output
//   (credit overflow / valid-without-request misuse detection).
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   req_i         per-input head-flit request for this output
//   valid_i       per-input flit valid
//   credit_ret_i  downstream returned one buffer slot
//   grant_o       one-hot owner, held for the whole packet
//   sel_o         encoded owner index for the crossbar mux
//   xfer_o        a flit moves from the owner this cycle
//   busy_o        port is locked to an owner
//   credit_cnt_o  current credit count
//   err_o         sticky credit/protocol error (OPA_CREDIT_CHECK_EN only)
// ---------------------------------------------------------------------------
module output_port_arbiter #(
  parameter int NUM_IN        = 5,
  parameter int FLITS_PER_PKT = 5,
  parameter int CREDIT_MAX    = 4,
  parameter int SELW          = 3,
  parameter int CW            = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req_i,
  input  logic [NUM_IN-1:0] valid_i,
  input  logic              credit_ret_i,
  output logic [NUM_IN-1:0] grant_o,
  output logic [SELW-1:0]   sel_o,
  output logic              xfer_o,
  output logic              busy_o,
  output logic [CW-1:0]     credit_cnt_o
`ifdef OPA_CREDIT_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int FW = (FLITS_PER_PKT > 1) ? $clog2(FLITS_PER_PKT) : 1;
  localparam logic [FW-1:0] LAST_FLIT = FW'(FLITS_PER_PKT - 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic                busy_q, busy_d;
  logic [FW-1:0]       flit_q, flit_d;
  logic [SELW-1:0]     rr_q, rr_d;
  logic [CW-1:0]       credit_q, credit_d;

  logic                win_found_s;
  logic [SELW-1:0]     win_idx_s;
  logic                xfer_s;
  int                  idx_v;

  // Flit moves only from the locked owner and only while a credit is free.
  assign xfer_s = (state_q == S_LOCK) && valid_i[sel_q] && (credit_q != {CW{1'b0}});

  // Round-robin search: first requester at or after rr_q, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {SELW{1'b0}};
    idx_v       = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx_v = int'(rr_q) + k;
      if (idx_v >= NUM_IN) begin
        idx_v = idx_v - NUM_IN;
      end else begin
        idx_v = idx_v;
      end
      if (!win_found_s && req_i[idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = SELW'(idx_v);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Arbitration / packet-lock FSM next state.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    flit_d  = flit_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d = S_LOCK;
          grant_d = NUM_IN'(1) << win_idx_s;
          sel_d   = win_idx_s;
          busy_d  = 1'b1;
          flit_d  = {FW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (xfer_s) begin
          if (flit_q == LAST_FLIT) begin
            // Tail flit: release the port and move the pointer past the owner.
            state_d = S_IDLE;
            grant_d = {NUM_IN{1'b0}};
            busy_d  = 1'b0;
            flit_d  = {FW{1'b0}};
            if (int'(sel_q) == NUM_IN - 1) begin
              rr_d = {SELW{1'b0}};
            end else begin
              rr_d = sel_q + SELW'(1);
            end
          end else begin
            flit_d = flit_q + FW'(1);
          end
        end else begin
          state_d = S_LOCK;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = {NUM_IN{1'b0}};
        busy_d  = 1'b0;
        flit_d  = {FW{1'b0}};
      end
    endcase
  end

  // Credit counter: simultaneous use and return cancel; returns saturate.
  always_comb begin
    credit_d = credit_q;
    case ({xfer_s, credit_ret_i})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q != CRED_FULL) begin
          credit_d = credit_q + CW'(1);
        end else begin
          credit_d = credit_q;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // State, owner and credit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= {NUM_IN{1'b0}};
      sel_q    <= {SELW{1'b0}};
      busy_q   <= 1'b0;
      flit_q   <= {FW{1'b0}};
      rr_q     <= {SELW{1'b0}};
      credit_q <= CRED_FULL;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      flit_q   <= flit_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
    end
  end

`ifdef OPA_CREDIT_CHECK_EN
  logic err_q, err_d;
  logic overflow_s, misuse_s;

  // Overflow: a return arrives with a full counter and nothing consuming it.
  // Misuse: during the arbitration cycle, an input shows a flit without a head request.
  assign overflow_s = credit_ret_i && !xfer_s && (credit_q == CRED_FULL);
  assign misuse_s   = (state_q == S_IDLE) && win_found_s && (|(valid_i & ~req_i));

  // Sticky error flag.
  always_comb begin
    err_d = err_q | overflow_s | misuse_s;
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  assign grant_o      = grant_q;
  assign sel_o        = sel_q;
  assign xfer_o       = xfer_s;
  assign busy_o       = busy_q;
  assign credit_cnt_o = credit_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_output_port_arbiter
//   Self-checking bench for output_port_arbiter. Expected owners of every flit
//   are queued when a packet is launched; a negedge monitor pops one per
//   observed xfer_o and compares. Directed checks cover reset, credit
//   boundaries, stalls, asynchronous reset and credit saturation.
// ---------------------------------------------------------------------------
module tb_output_port_arbiter;

  localparam int NUM_IN = 5;
  localparam int SELW   = 3;
  localparam int CW     = 3;

  logic              clk;
  logic              rst;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] valid;
  logic              credit_ret;
  logic              man_ret;
  logic              auto_en;
  logic              auto_pulse;
  logic              last_xfer;
  logic [NUM_IN-1:0] grant;
  logic [SELW-1:0]   sel;
  logic              xfer;
  logic              busy;
  logic [CW-1:0]     credit;
`ifdef OPA_CREDIT_CHECK_EN
  logic              err;
`endif

  int checks;
  int failures;
  int exp_q[$];

  assign credit_ret = man_ret | auto_pulse;

  output_port_arbiter #(
    .NUM_IN(5), .FLITS_PER_PKT(5), .CREDIT_MAX(4), .SELW(3), .CW(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .valid_i(valid),
    .credit_ret_i(credit_ret),
    .grant_o(grant),
    .sel_o(sel),
    .xfer_o(xfer),
    .busy_o(busy),
    .credit_cnt_o(credit)
`ifdef OPA_CREDIT_CHECK_EN
    ,
    .err_o(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input int owner);
    for (int f = 0; f < 5; f++) exp_q.push_back(owner);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_val("drain_timeout", exp_q.size(), 0);
  endtask

  // Downstream sink: returns one credit the cycle after each transfer.
  always @(negedge clk) last_xfer = xfer;
  always @(posedge clk) begin
    #1;
    auto_pulse = auto_en & last_xfer;
  end

  // Scoreboard monitor: one expected owner consumed per observed flit.
  always @(negedge clk) begin
    logic [NUM_IN-1:0] exp_g;
    int owner;
    if (busy) begin
      exp_g = NUM_IN'(1) << sel;
      check_val("grant_onehot", grant, exp_g);
    end else begin
      check_val("idle_no_xfer", xfer, 0);
    end
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check_val("xfer_unexpected", xfer, 0);
      end else begin
        owner = exp_q.pop_front();
        check_val("xfer_owner", sel, owner);
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req = '0; valid = '0; man_ret = 1'b0; auto_en = 1'b0;
    auto_pulse = 1'b0; last_xfer = 1'b0;
    #1 rst = 1'b0;
    #2;
    check_val("rst_grant", grant, 0);
    check_val("rst_sel", sel, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_xfer", xfer, 0);
    check_val("rst_credit", credit, 4);
`ifdef OPA_CREDIT_CHECK_EN
    check_val("rst_err", err, 0);
`endif
    step();
    rst = 1'b1;
    step();

    // Idle with valid but no request: nothing moves.
    valid = 5'b11111;
    #1;
    check_val("idle_valid_no_xfer", xfer, 0);
    valid = '0;
    step();

    // Single request from input 2, credits run out before the tail.
    push_pkt(2);
    req = 5'b00100; valid = 5'b00100;
    step();
    check_val("sr_grant", grant, 5'b00100);
    check_val("sr_sel", sel, 2);
    check_val("sr_busy", busy, 1);
    check_val("sr_credit0", credit, 4);
    check_val("sr_first_xfer", xfer, 1);
    req = '0;
    repeat (4) step();
    check_val("sr_credit_empty", credit, 0);
    check_val("sr_stall_xfer", xfer, 0);
    check_val("sr_stall_busy", busy, 1);
    man_ret = 1'b1;
    #1;
    check_val("sr_ret_no_xfer", xfer, 0);
    step();
    man_ret = 1'b0;
    #1;
    check_val("sr_credit_one", credit, 1);
    check_val("sr_tail_xfer", xfer, 1);
    step();
    check_val("sr_credit_back0", credit, 0);
    check_val("sr_release_busy", busy, 0);
    check_val("sr_release_grant", grant, 0);
    check_val("sr_queue_empty", exp_q.size(), 0);
    valid = '0;
    man_ret = 1'b1;
    repeat (4) step();
    man_ret = 1'b0;
    check_val("sr_credit_refill", credit, 4);

    // Pointer advanced past input 2: all-request picks input 3.
    auto_en = 1'b1;
    push_pkt(3);
    req = 5'b11111; valid = 5'b11111;
    step();
    check_val("rr3_sel", sel, 3);
    check_val("rr3_grant", grant, 5'b01000);
    drain(20);
    req = '0; valid = '0;
    repeat (3) step();
    check_val("rr3_credit", credit, 4);
    auto_en = 1'b0;

    // Fresh reset, then fairness sweep 0,1,2,3,4,0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    auto_en = 1'b1;
    push_pkt(0); push_pkt(1); push_pkt(2); push_pkt(3); push_pkt(4); push_pkt(0);
    req = 5'b11111; valid = 5'b11111;
    drain(100);
    req = '0; valid = '0;
    repeat (3) step();
    check_val("rr_idle_busy", busy, 0);
    check_val("rr_credit", credit, 4);
    auto_en = 1'b0;

    // Owner stall after two flits, then same-cycle use and return at count 2.
    push_pkt(1);
    req = 5'b00010; valid = 5'b00010;
    step();
    check_val("st_grant", grant, 5'b00010);
    req = '0;
    step();
    check_val("st_credit3", credit, 3);
    step();
    check_val("st_credit2", credit, 2);
    valid = '0;
    #1;
    check_val("st_xfer_off", xfer, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("st_hold_xfer", xfer, 0);
      check_val("st_hold_grant", grant, 5'b00010);
      check_val("st_hold_credit", credit, 2);
    end
    valid = 5'b00010; man_ret = 1'b1;
    #1;
    check_val("st_resume_xfer", xfer, 1);
    step();
    man_ret = 1'b0;
    check_val("st_both_credit", credit, 2);
    step();
    check_val("st_credit1", credit, 1);
    step();
    check_val("st_credit0", credit, 0);
    check_val("st_release", busy, 0);
    check_val("st_queue_empty", exp_q.size(), 0);
    valid = '0;
    man_ret = 1'b1;
    repeat (4) step();
    man_ret = 1'b0;
    check_val("st_refill", credit, 4);

    // Asynchronous reset in the middle of flit 3.
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
    req = 5'b01000; valid = 5'b01000;
    step();
    req = '0;
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    check_val("ar_grant", grant, 0);
    check_val("ar_busy", busy, 0);
    check_val("ar_credit", credit, 4);
    check_val("ar_xfer", xfer, 0);
    check_val("ar_queue_empty", exp_q.size(), 0);
    valid = '0;
    step();
    rst = 1'b1;
    step();

    // Five returns with no traffic: count stays saturated.
`ifdef OPA_CREDIT_CHECK_EN
    check_val("sat_err_before", err, 0);
`endif
    man_ret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("sat_credit", credit, 4);
`ifdef OPA_CREDIT_CHECK_EN
      check_val("sat_err_set", err, 1);
`endif
    end
    man_ret = 1'b0;
`ifdef OPA_CREDIT_CHECK_EN
    repeat (2) step();
    check_val("sat_err_held", err, 1);
    rst = 1'b0;
    #1;
    check_val("sat_err_cleared", err, 0);
    step();
    rst = 1'b1;
`endif
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
